mole_round_ctrl: RTL and testbench

Round sequencer for the whack-a-mole game. It chooses which moles light each round using an LFSR and holds them for a fixed window. During that window it captures player switch strikes on lit moles. At round end it emits a one-cycle hit mask on `hit_reg`, which feeds the scoring bit counter directly; that counter accumulates every cycle, so the mask is strictly a single-cycle pulse.

---
 rtl/mole_round_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mole_round_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: LFSR mole pick, timed SHOW window, strike capture, one-cycle hit mask.
// Optional build macro MOLE_WHACK_CLEAR_EN: struck moles go dark for the rest of the SHOW window.
module mole_round_ctrl #(
    parameter int unsigned ROUND_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES   = 5_000_000,
    parameter int unsigned NUM_ROUNDS   = 30,
    parameter int unsigned MAX_MOLES    = 6,
    parameter logic [17:0] SEED         = 18'h2A5F3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] sw,
    output logic [17:0] led_moles,
    output logic [17:0] hit_reg,
    output logic        round_done,
    output logic [7:0]  round_num,
    output logic        game_over
);

    localparam int unsigned MAX_CYC = (ROUND_CYCLES > GAP_CYCLES) ? ROUND_CYCLES : GAP_CYCLES;
    localparam int unsigned TW = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] ROUND_LAST = TW'(ROUND_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [7:0]    ROUNDS_END = 8'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        SCORE,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [17:0]   lfsr_q, lfsr_d;
    logic          start_meta_q, start_meta_d;
    logic          start_s_q, start_s_d;
    logic          start_prev_q, start_prev_d;
    logic [17:0]   sw_meta_q, sw_meta_d;
    logic [17:0]   sw_s_q, sw_s_d;
    logic [17:0]   sw_prev_q, sw_prev_d;
    logic [17:0]   moles_q, moles_d;
    logic [17:0]   hit_acc_q, hit_acc_d;
    logic [17:0]   hit_reg_q, hit_reg_d;
    logic          round_done_q, round_done_d;
    logic [7:0]    round_num_q, round_num_d;
    logic          game_over_q, game_over_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          start_rise;
    logic [17:0]   sw_rise;
    logic [17:0]   hit_new;
    logic [17:0]   picked;
    logic [7:0]    round_next;

    // Keep the lowest-index set bits, at most MAX_MOLES of them; never return an empty mask.
    function automatic logic [17:0] pick_moles(input logic [17:0] v);
        logic [17:0] m;
        int unsigned cnt;
        m   = '0;
        cnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (v[i] && (cnt < MAX_MOLES)) begin
                m[i] = 1'b1;
                cnt++;
            end
        end
        if (m == '0) begin
            m = 18'h00001;
        end
        return m;
    endfunction

    always_comb begin
        start_meta_d = start;
        start_s_d    = start_meta_q;
        start_prev_d = start_s_q;
        sw_meta_d    = sw;
        sw_s_d       = sw_meta_q;
        sw_prev_d    = sw_s_q;
        lfsr_d       = {lfsr_q[16:0], lfsr_q[17] ^ lfsr_q[10]};
    end

    assign start_rise = start_s_q & ~start_prev_q;
    assign sw_rise    = sw_s_q & ~sw_prev_q;
    assign hit_new    = hit_acc_q | (sw_rise & moles_q);
    assign picked     = pick_moles(lfsr_q);
    assign round_next = (round_num_q >= ROUNDS_END) ? ROUNDS_END : round_num_q + 8'd1;

    // hit_reg/round_done are loaded on the SHOW exit so they are valid exactly during SCORE.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        moles_d      = moles_q;
        hit_acc_d    = hit_acc_q;
        hit_reg_d    = '0;
        round_done_d = 1'b0;
        round_num_d  = round_num_q;
        game_over_d  = game_over_q;
        case (state_q)
            IDLE: begin
                timer_d   = '0;
                hit_acc_d = '0;
                if (start_rise) begin
                    round_num_d = '0;
                    game_over_d = 1'b0;
                    moles_d     = picked;
                    state_d     = SHOW;
                end
            end
            SHOW: begin
                hit_acc_d = hit_new;
                timer_d   = timer_q + TW'(1);
                if ((timer_q == ROUND_LAST) || (hit_new == moles_q)) begin
                    hit_reg_d    = hit_new;
                    round_done_d = 1'b1;
                    timer_d      = '0;
                    state_d      = SCORE;
                end
            end
            SCORE: begin
                hit_acc_d   = '0;
                timer_d     = '0;
                round_num_d = round_next;
                if (round_next == ROUNDS_END) begin
                    game_over_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                hit_acc_d = '0;
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    moles_d = picked;
                    state_d = SHOW;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        led_moles = '0;
        if (state_q == SHOW) begin
`ifdef MOLE_WHACK_CLEAR_EN
            led_moles = moles_q & ~hit_acc_q;
`else
            led_moles = moles_q;
`endif
        end
    end

    assign hit_reg    = hit_reg_q;
    assign round_done = round_done_q;
    assign round_num  = round_num_q;
    assign game_over  = game_over_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            start_meta_q <= 1'b0;
            start_s_q    <= 1'b0;
            start_prev_q <= 1'b0;
            sw_meta_q    <= '0;
            sw_s_q       <= '0;
            sw_prev_q    <= '0;
            moles_q      <= '0;
            hit_acc_q    <= '0;
            hit_reg_q    <= '0;
            round_done_q <= 1'b0;
            round_num_q  <= '0;
            game_over_q  <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            start_meta_q <= start_meta_d;
            start_s_q    <= start_s_d;
            start_prev_q <= start_prev_d;
            sw_meta_q    <= sw_meta_d;
            sw_s_q       <= sw_s_d;
            sw_prev_q    <= sw_prev_d;
            moles_q      <= moles_d;
            hit_acc_q    <= hit_acc_d;
            hit_reg_q    <= hit_reg_d;
            round_done_q <= round_done_d;
            round_num_q  <= round_num_d;
            game_over_q  <= game_over_d;
            timer_q      <= timer_d;
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl with short round/gap timing and a 3-round game.
module tb_mole_round_ctrl;

    localparam int unsigned ROUND_CYCLES = 16;
    localparam int unsigned GAP_CYCLES   = 4;
    localparam int unsigned NUM_ROUNDS   = 3;
    localparam int unsigned MAX_MOLES    = 6;
    localparam logic [17:0] SEED         = 18'h2A5F3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [17:0] sw;
    logic [17:0] led_moles;
    logic [17:0] hit_reg;
    logic        round_done;
    logic [7:0]  round_num;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    logic [17:0] m_lfsr;
    logic [17:0] cur_moles;
    logic [17:0] first_moles;

    always #5 clk = ~clk;

    mole_round_ctrl #(
        .ROUND_CYCLES(ROUND_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .NUM_ROUNDS  (NUM_ROUNDS),
        .MAX_MOLES   (MAX_MOLES),
        .SEED        (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sw        (sw),
        .led_moles (led_moles),
        .hit_reg   (hit_reg),
        .round_done(round_done),
        .round_num (round_num),
        .game_over (game_over)
    );

    // Reference LFSR: 18-bit Fibonacci, taps 18 and 11, free-running outside reset.
    always @(posedge clk) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[16:0], m_lfsr[17] ^ m_lfsr[10]};
    end

    function automatic logic [17:0] model_pick(input logic [17:0] v);
        logic [17:0] m;
        int n;
        m = '0;
        n = 0;
        for (int i = 0; i < 18; i++) begin
            if (v[i] && n < int'(MAX_MOLES)) begin
                m[i] = 1'b1;
                n++;
            end
        end
        if (m == '0) m = 18'h00001;
        return m;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(output logic [17:0] m);
        start = 1'b1;
        tick;
        total++;
        if (led_moles !== 18'h0) begin
            bad++;
            $display("[TB] FAIL start_lat1: led=%h expected 0", led_moles);
        end
        start = 1'b0;
        tick;
        total++;
        if (led_moles !== 18'h0) begin
            bad++;
            $display("[TB] FAIL start_lat2: led=%h expected 0", led_moles);
        end
        m = model_pick(m_lfsr);
        tick;
        total++;
        if (led_moles !== m) begin
            bad++;
            $display("[TB] FAIL show_mask: led=%h expected %h", led_moles, m);
        end
        total++;
        if (led_moles == 18'h0 || $countones(led_moles) > 6) begin
            bad++;
            $display("[TB] FAIL mask_popcount: led=%h expected nonzero with <=6 bits", led_moles);
        end
    endtask

    task automatic release_and_start(output logic [17:0] m);
        reset = 1'b1;
        repeat (3) begin
            tick;
            total++;
            if (hit_reg !== 18'h0 || round_done !== 1'b0 || led_moles !== 18'h0) begin
                bad++;
                $display("[TB] FAIL idle_quiet: hit=%h done=%b led=%h expected 0/0/0", hit_reg, round_done, led_moles);
            end
        end
        start_game(m);
    endtask

    task automatic gap_to_show(input logic [7:0] exp_num);
        for (int g = 1; g <= int'(GAP_CYCLES); g++) begin
            tick;
            total++;
            if (led_moles !== 18'h0 || round_done !== 1'b0 || hit_reg !== 18'h0 || round_num !== exp_num) begin
                bad++;
                $display("[TB] FAIL gap_%0d: led=%h done=%b hit=%h num=%0d expected 0/0/0/%0d",
                         g, led_moles, round_done, hit_reg, round_num, exp_num);
            end
            if (g == int'(GAP_CYCLES)) cur_moles = model_pick(m_lfsr);
        end
        tick;
        total++;
        if (led_moles !== cur_moles) begin
            bad++;
            $display("[TB] FAIL gap_to_show: led=%h expected %h", led_moles, cur_moles);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        sw    = 18'h3FFFF;
        repeat (4) begin
            tick;
            total++;
            if (led_moles !== 18'h0 || hit_reg !== 18'h0 || round_done !== 1'b0 ||
                round_num !== 8'h0 || game_over !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_outputs: led=%h hit=%h done=%b num=%0d over=%b expected all 0",
                         led_moles, hit_reg, round_done, round_num, game_over);
            end
        end
        start = 1'b0;
        sw    = 18'h0;
        repeat (2) tick;
        release_and_start(cur_moles);
        first_moles = cur_moles;
        $display("[TB] first round mask %h", first_moles);
    endtask

    task automatic test_no_hits;
        for (int c = 2; c <= int'(ROUND_CYCLES); c++) begin
            tick;
            total++;
            if (led_moles !== cur_moles || round_done !== 1'b0 || hit_reg !== 18'h0) begin
                bad++;
                $display("[TB] FAIL show_hold_%0d: led=%h done=%b hit=%h expected %h/0/0",
                         c, led_moles, round_done, hit_reg, cur_moles);
            end
        end
        tick;
        total++;
        if (round_done !== 1'b1 || hit_reg !== 18'h0) begin
            bad++;
            $display("[TB] FAIL score_no_hit: done=%b hit=%h expected 1/0", round_done, hit_reg);
        end
        gap_to_show(8'd1);
    endtask

    task automatic test_one_hit;
        logic [17:0] lit, unlit, exp_led;
        int exp_score;
        lit       = cur_moles & (~cur_moles + 18'd1);
        unlit     = ~cur_moles & (cur_moles + 18'd1);
        exp_score = (lit == cur_moles) ? 4 : int'(ROUND_CYCLES) + 1;
`ifdef MOLE_WHACK_CLEAR_EN
        exp_led = cur_moles & ~lit;
`else
        exp_led = cur_moles;
`endif
        sw = lit | unlit;
        for (int idx = 2; idx < exp_score; idx++) begin
            tick;
            total++;
            if (round_done !== 1'b0 || hit_reg !== 18'h0) begin
                bad++;
                $display("[TB] FAIL hit_quiet_%0d: done=%b hit=%h expected 0/0", idx, round_done, hit_reg);
            end
            if (idx == 4) begin
                total++;
                if (led_moles !== exp_led) begin
                    bad++;
                    $display("[TB] FAIL hit_led: led=%h expected %h", led_moles, exp_led);
                end
            end
        end
        tick;
        total++;
        if (round_done !== 1'b1 || hit_reg !== lit) begin
            bad++;
            $display("[TB] FAIL one_hit_mask: done=%b hit=%h expected 1/%h", round_done, hit_reg, lit);
        end
        sw = 18'h0;
        gap_to_show(8'd2);
    endtask

    task automatic test_early_clear;
        logic [17:0] first, rest, exp_led;
        first = cur_moles & (~cur_moles + 18'd1);
        rest  = cur_moles & ~first;
`ifdef MOLE_WHACK_CLEAR_EN
        exp_led = cur_moles & ~first;
`else
        exp_led = cur_moles;
`endif
        sw = first;
        tick;
        sw = cur_moles;
        tick;
        tick;
        if (rest == 18'h0) begin
            total++;
            if (round_done !== 1'b1 || hit_reg !== cur_moles) begin
                bad++;
                $display("[TB] FAIL early_single: done=%b hit=%h expected 1/%h", round_done, hit_reg, cur_moles);
            end
        end else begin
            total++;
            if (round_done !== 1'b0 || led_moles !== exp_led) begin
                bad++;
                $display("[TB] FAIL early_partial: done=%b led=%h expected 0/%h", round_done, led_moles, exp_led);
            end
            tick;
            total++;
            if (round_done !== 1'b1 || hit_reg !== cur_moles) begin
                bad++;
                $display("[TB] FAIL early_clear: done=%b hit=%h expected 1/%h", round_done, hit_reg, cur_moles);
            end
        end
        tick;
        total++;
        if (round_num !== 8'd3 || game_over !== 1'b1 || round_done !== 1'b0 ||
            hit_reg !== 18'h0 || led_moles !== 18'h0) begin
            bad++;
            $display("[TB] FAIL final_round: num=%0d over=%b done=%b hit=%h led=%h expected 3/1/0/0/0",
                     round_num, game_over, round_done, hit_reg, led_moles);
        end
        sw = 18'h0;
    endtask

    task automatic test_game_over;
        for (int i = 0; i < 6; i++) begin
            sw = (i == 1) ? 18'h3FFFF : 18'h0;
            tick;
            total++;
            if (game_over !== 1'b1 || round_num !== 8'd3 || led_moles !== 18'h0 || hit_reg !== 18'h0) begin
                bad++;
                $display("[TB] FAIL game_over_hold: over=%b num=%0d led=%h hit=%h expected 1/3/0/0",
                         game_over, round_num, led_moles, hit_reg);
            end
        end
        start_game(cur_moles);
        total++;
        if (game_over !== 1'b0 || round_num !== 8'd0) begin
            bad++;
            $display("[TB] FAIL restart_clear: over=%b num=%0d expected 0/0", game_over, round_num);
        end
    endtask

    task automatic test_reset_mid_round;
        logic [17:0] m;
        repeat (7) tick;
        reset = 1'b0;
        repeat (3) begin
            tick;
            total++;
            if (led_moles !== 18'h0 || hit_reg !== 18'h0 || round_done !== 1'b0 ||
                round_num !== 8'h0 || game_over !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_mid: led=%h hit=%h done=%b num=%0d over=%b expected all 0",
                         led_moles, hit_reg, round_done, round_num, game_over);
            end
        end
        release_and_start(m);
        total++;
        if (m !== first_moles || led_moles !== first_moles) begin
            bad++;
            $display("[TB] FAIL lfsr_restart: led=%h expected %h", led_moles, first_moles);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        sw    = 18'h0;
        test_reset;
        test_no_hits;
        test_one_hit;
        test_early_clear;
        test_game_over;
        test_reset_mid_round;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
